mux_ctrl_spi: RTL and testbench
===============================

# mux_ctrl_spi

SPI-programmable controller for an N-channel analog multiplexer with complementary switch drive. It generalises the fixed 8-channel control macro with a parametrised channel count, a register file and static or scan modes. It adds break-before-make sequencing and register readback. It sits between the digital input pads (sck, mosi, ss, clk, rst) and the analog mux switch-control bus, with miso returned to an output pad.

## Interface
- CHANNELS, 8: number of mux channels, 2..16.
- BBM_CYCLES, 4: all-off gap in clk cycles on every channel change, ≥1.
- DIV_W, 16: width of the scan dwell counter.

- clk  in  1  system clock; all logic is in this domain.
- rst  in  1  reset, asynchronous, active-high.
- sck  in  1  SPI clock, mode 0, asynchronous to clk.
- mosi  in  1  SPI data in, MSB first.
- ss  in  1  SPI select, active-low.
- miso  out  1  SPI data out.
- dout_p  out  CHANNELS  switch enables, one-hot or all-zero.
- dout_n  out  CHANNELS  always the bitwise complement of dout_p.
- busy  out  1  high while a break-before-make gap is in progress.

## Operation
- **Input synchronisers:** sck, mosi and ss each pass through a 2-FF synchroniser to clk. Edges are detected on the synchronised signals.
- **Frame format:** 24 bits, MSB first, sampled on sck rising edges while ss is low.
  - bit23 is W (1 = write).
  - bits18:16 are ADDR; bits22:19 are ignored.
  - bits15:0 are DATA.
- **Frame commit:** the bit counter resets on ss falling. A write commits on ss rising only if exactly 24 bits were received. Any other frame length is discarded with no register change.
- **Registers** (unused upper bits read 0):
  - 0 EN: channel enable mask [CHANNELS-1:0]. Reset 0.
  - 1 MODE: bits1:0. 0 = off, 1 = static, 2 = scan, 3 = off. Reset 0.
  - 2 SEL: static channel index [3:0]. Reset 0.
  - 3 DIV: scan dwell [DIV_W-1:0]. Dwell is DIV+1 clk cycles. Reset 0.
  - 4 STATUS (read-only): bits3:0 current channel, bit4 channel on, bit5 busy.
  - 5–7: read 0; writes ignored.
- **Readback:** when W = 0, the register at ADDR is latched after bit 8 is sampled. Data bits 15..0 are driven on miso, each updated on a synchronised sck falling edge. Before that point, and whenever ss is high, miso = 0.
- **Target channel:**
  - Off mode: none.
  - Static mode: SEL, if SEL < CHANNELS and EN[SEL] = 1; otherwise none.
  - Scan mode: steps through the set EN bits in ascending order and wraps from highest to lowest. If EN = 0, none.
- **Switch FSM:**
  - OFF: dout_p = 0. Moves to BBM when a target exists.
  - BBM: dout_p = 0, busy = 1, lasts BBM_CYCLES cycles. Then moves to ON with the target latched at BBM exit.
  - ON: dout_p = one-hot of the current channel. Moves to BBM when the target changes (to another channel or to none).
  - BBM exit with no target goes to OFF.
- **Scan counter:** counts in ON only. On reaching DIV it requests the next enabled channel and reloads to 0. A single enabled channel in scan mode stays ON with no BBM.
- **Register writes during BBM:** the new target is evaluated at BBM exit; BBM is not restarted.

## Timing
- **Reset values:** dout_p = 0, dout_n = all-ones, miso = 0, busy = 0, FSM = OFF, all registers = 0. Reset applies immediately and asynchronously, including mid-frame and mid-BBM. The partial frame is lost.
- **Clock ratio:** clk must be ≥ 8× sck frequency. ss setup/hold relative to sck must be ≥ 3 clk cycles.
- **Write-to-output latency:** a register write takes effect 4 clk cycles after ss rises at the pin: 2 sync + 1 edge detect + 1 commit. The first dout_p change, to 0, follows on the next cycle.
- **Channel change:** the last cycle of old one-hot is followed by exactly BBM_CYCLES cycles of dout_p = 0. The new one-hot follows on the next cycle.
- **No overlap:** there is never a cycle with two bits of dout_p set, and never a direct one-hot-to-one-hot transition.
- **Scan dwell:** each channel is ON for exactly DIV+1 cycles, plus BBM_CYCLES off between channels.

## Test plan
- **Reset:** rst asserted mid-frame and mid-BBM -> dout_p = 0, dout_n = all-ones, miso = 0 immediately. A later write of EN = 0xFF works normally.
- **Static mode:** write EN = 0x0F, SEL = 2, MODE = 1 -> dout_p = 0x04 after a 4-cycle gap. Then write SEL = 5 (EN[5] = 0) -> BBM, then dout_p = 0.
- **Break-before-make:** with SEL changing 2→3 -> dout_p goes 0x04, then 0x00 for exactly 4 cycles, then 0x08. busy is high for those 4 cycles only. Every cycle has dout_n = ~dout_p.
- **Scan:** EN = 0x85, DIV = 9, MODE = 2 -> sequence ch0, ch2, ch7, ch0… Each is ON for 10 cycles with 4-cycle gaps. EN = 0x00 mid-scan -> OFF.
- **Readback:** write DIV = 0xA5C3, then a 24-bit read of ADDR 3 -> miso shifts 0xA5C3 MSB first. A read of ADDR 6 -> 0x0000.
- **Malformed frames:** 23-bit and 25-bit write frames -> no register change, and dout_p is unchanged.

Source files
------------

// File: rtl/mux_ctrl_spi.sv
// SPI-programmed N-channel analog mux driver with break-before-make and register readback.
// Latency: a committed write reaches the registers 4 clk after ss rises; outputs are registered one clk later.
// No backpressure: SPI frames are consumed as they arrive, and malformed frames are dropped.
module mux_ctrl_spi #(
  parameter int CHANNELS   = 8,
  parameter int BBM_CYCLES = 4,
  parameter int DIV_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                mosi,
  input  logic                ss,
  output logic                miso,
  output logic [CHANNELS-1:0] dout_p,
  output logic [CHANNELS-1:0] dout_n,
  output logic                busy
);

  localparam int IDX_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int BBM_W = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
  localparam logic [4:0]       CH_LIM   = 5'(CHANNELS);
  localparam logic [3:0]       CH_LAST  = 4'(CHANNELS - 1);
  localparam logic [BBM_W-1:0] BBM_LAST = BBM_W'(BBM_CYCLES - 1);

  typedef enum logic [1:0] {ST_OFF, ST_BBM, ST_ON} state_e;

  // synchroniser and edge-detect state
  logic [2:0] sck_s_q, ss_s_q;
  logic [1:0] mosi_s_q;
  logic       sck_rise_q, sck_fall_q, ss_rise_q, ss_fall_q, ss_lvl_q, mosi_bit_q;

  // frame capture and readback
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q;
  logic [15:0] rd_sh_q, rd_val;
  logic        rd_act_q, miso_q;

  // register file
  logic [CHANNELS-1:0] en_q;
  logic [1:0]          mode_q;
  logic [3:0]          sel_q;
  logic [DIV_W-1:0]    div_q;

  // switch sequencing
  state_e              state_q, state_d;
  logic [3:0]          cur_q, cur_d, ptr_q, ptr_d, tgt_ch, nxt_start;
  logic [BBM_W-1:0]    bbm_q, bbm_d;
  logic [DIV_W-1:0]    dwell_q, dwell_d;
  logic                tgt_vld, expire;
  logic [4:0]          scan_hit;
  logic [CHANNELS-1:0] oh_d, dout_p_q, dout_n_q;
  logic                busy_q;

  // First set bit of mask at or above start, wrapping; returns {found, index}.
  function automatic logic [4:0] first_from(input logic [3:0] start, input logic [CHANNELS-1:0] mask);
    int         idx;
    logic       found;
    logic [3:0] res;
    found = 1'b0;
    res   = 4'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(start) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && mask[IDX_W'(idx)]) begin
        found = 1'b1;
        res   = 4'(idx);
      end
    end
    return {found, res};
  endfunction

  // Two-flop synchronisers plus registered single-cycle edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s_q    <= '0;
      ss_s_q     <= '1;
      mosi_s_q   <= '0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      ss_rise_q  <= 1'b0;
      ss_fall_q  <= 1'b0;
      ss_lvl_q   <= 1'b1;
      mosi_bit_q <= 1'b0;
    end else begin
      sck_s_q    <= {sck_s_q[1:0], sck};
      ss_s_q     <= {ss_s_q[1:0], ss};
      mosi_s_q   <= {mosi_s_q[0], mosi};
      sck_rise_q <= sck_s_q[1] & ~sck_s_q[2];
      sck_fall_q <= ~sck_s_q[1] & sck_s_q[2];
      ss_rise_q  <= ss_s_q[1] & ~ss_s_q[2];
      ss_fall_q  <= ~ss_s_q[1] & ss_s_q[2];
      ss_lvl_q   <= ss_s_q[1];
      mosi_bit_q <= mosi_s_q[1];
    end
  end

  assign shift_d = {shift_q[22:0], mosi_bit_q};

  // Shift in MOSI on each sck rise inside a frame; count bits saturating so over-long frames stay invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (ss_fall_q) begin
      bit_cnt_q <= '0;
    end else if (sck_rise_q && !ss_lvl_q) begin
      shift_q <= shift_d;
      if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
    end
  end

  // Readback mux, addressed by the frame header as it completes its 8th bit.
  always_comb begin
    rd_val = '0;
    case (shift_d[2:0])
      3'd0: rd_val[CHANNELS-1:0] = en_q;
      3'd1: rd_val[1:0]          = mode_q;
      3'd2: rd_val[3:0]          = sel_q;
      3'd3: rd_val[DIV_W-1:0]    = div_q;
      3'd4: rd_val[5:0]          = {busy_q, state_q == ST_ON, cur_q};
      default: rd_val = '0;
    endcase
  end

  // Latch the read word after the header, then present one bit per sck fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sh_q  <= '0;
      rd_act_q <= 1'b0;
      miso_q   <= 1'b0;
    end else if (ss_lvl_q) begin
      rd_act_q <= 1'b0;
      miso_q   <= 1'b0;
    end else if (sck_rise_q && bit_cnt_q == 5'd7 && !shift_d[7]) begin
      rd_sh_q  <= rd_val;
      rd_act_q <= 1'b1;
    end else if (sck_fall_q && rd_act_q) begin
      miso_q  <= rd_sh_q[15];
      rd_sh_q <= {rd_sh_q[14:0], 1'b0};
    end
  end

  // Commit a write only when ss closes a frame of exactly 24 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      mode_q <= '0;
      sel_q  <= '0;
      div_q  <= '0;
    end else if (ss_rise_q && bit_cnt_q == 5'd24 && shift_q[23]) begin
      case (shift_q[18:16])
        3'd0: en_q   <= shift_q[CHANNELS-1:0];
        3'd1: mode_q <= shift_q[1:0];
        3'd2: sel_q  <= shift_q[3:0];
        3'd3: div_q  <= shift_q[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  // Target channel; in scan mode a dwell expiry already points at the next enabled channel.
  always_comb begin
    tgt_vld   = 1'b0;
    tgt_ch    = '0;
    expire    = (state_q == ST_ON) && (dwell_q == div_q);
    nxt_start = (cur_q == CH_LAST) ? 4'd0 : cur_q + 4'd1;
    scan_hit  = first_from(expire ? nxt_start : ptr_q, en_q);
    case (mode_q)
      2'd1: begin
        tgt_vld = ({1'b0, sel_q} < CH_LIM) && en_q[sel_q[IDX_W-1:0]];
        tgt_ch  = sel_q;
      end
      2'd2: begin
        tgt_vld = scan_hit[4];
        tgt_ch  = scan_hit[3:0];
      end
      default: ;
    endcase
  end

  // Switch FSM next state: every channel change passes through a full all-off gap.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    bbm_d   = bbm_q;
    dwell_d = '0;
    ptr_d   = ptr_q;
    oh_d    = '0;
    case (state_q)
      ST_OFF: begin
        if (tgt_vld) begin
          state_d = ST_BBM;
          bbm_d   = '0;
        end
      end
      ST_BBM: begin
        if (bbm_q == BBM_LAST) begin
          bbm_d = '0;
          if (tgt_vld) begin
            state_d = ST_ON;
            cur_d   = tgt_ch;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          bbm_d = bbm_q + BBM_W'(1);
        end
      end
      ST_ON: begin
        if (!tgt_vld || tgt_ch != cur_q) begin
          state_d = ST_BBM;
          bbm_d   = '0;
        end else if (!expire) begin
          dwell_d = dwell_q + DIV_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (mode_q == 2'd2 && tgt_vld && (expire || (state_q == ST_BBM && state_d == ST_ON)))
      ptr_d = tgt_ch;
    if (state_d == ST_ON) oh_d[cur_d[IDX_W-1:0]] = 1'b1;
  end

  // FSM state and registered switch-drive outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cur_q    <= '0;
      ptr_q    <= '0;
      bbm_q    <= '0;
      dwell_q  <= '0;
      dout_p_q <= '0;
      dout_n_q <= '1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ptr_q    <= ptr_d;
      bbm_q    <= bbm_d;
      dwell_q  <= dwell_d;
      dout_p_q <= oh_d;
      dout_n_q <= ~oh_d;
      busy_q   <= (state_d == ST_BBM);
    end
  end

  assign miso   = miso_q;
  assign dout_p = dout_p_q;
  assign dout_n = dout_n_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mux_ctrl_spi.sv
// Directed bench for mux_ctrl_spi with an 8-channel, 4-cycle-gap build.
// SPI runs at 1/16 of clk; all stimulus changes on clk falling edges.
// Outputs are sampled on clk falling edges, away from the active edge.
module tb_mux_ctrl_spi;

  logic       clk = 1'b0;
  logic       rst, sck, mosi, ss, miso, busy;
  logic [7:0] dout_p, dout_n;
  int         errs = 0;
  int         checks = 0;
  logic [15:0] rdat;

  always #5 clk = ~clk;

  mux_ctrl_spi #(.CHANNELS(8), .BBM_CYCLES(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss(ss),
    .miso(miso), .dout_p(dout_p), .dout_n(dout_n), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] frm(input logic w, input logic [2:0] a, input logic [15:0] d);
    return {8'h00, w, 4'h0, a, d};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits MSB first (bit n-1 of v first); capture miso on sck rises 9..24.
  task automatic shift_bits(input int n, input logic [31:0] v, output logic [15:0] rd);
    rd = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[5'(i)];
      #80;
      sck = 1'b1;
      if ((n - 1 - i) >= 8 && (n - 1 - i) < 24) rd = {rd[14:0], miso};
      #80;
      sck = 1'b0;
    end
  endtask

  // Full frame; ss rises right after a clk falling edge so latency counts start clean.
  task automatic xfer(input int n, input logic [31:0] v, output logic [15:0] rd);
    @(negedge clk);
    ss = 1'b0;
    #50;
    shift_bits(n, v, rd);
    #50;
    @(negedge clk);
    ss = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    logic [15:0] unused_rd;
    xfer(24, frm(1'b1, a, d), unused_rd);
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    xfer(24, frm(1'b0, a, 16'h0), d);
  endtask

  initial begin : stim
    int zeros, busys, badn, multi, w, n;
    logic [7:0] v;
    logic [7:0] seg_val [6];
    int         seg_len [6];
    seg_val = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h80, 8'h00};
    seg_len = '{10, 4, 10, 4, 10, 4};

    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss = 1'b1;
    idle(3);
    check("rst_dout_p", 32'(dout_p), 32'h00);
    check("rst_dout_n", 32'(dout_n), 32'hFF);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(5);

    // Static mode with write-to-output latency
    wr(3'd0, 16'h000F); idle(10);
    wr(3'd2, 16'h0002); idle(10);
    check("mode_off_dout", 32'(dout_p), 32'h00);
    wr(3'd1, 16'h0001);
    idle(4);
    check("lat_n4_busy", 32'(busy), 32'h0);
    idle(1);
    check("lat_n5_busy", 32'(busy), 32'h1);
    check("lat_n5_dout", 32'(dout_p), 32'h00);
    idle(3);
    check("lat_n8_busy", 32'(busy), 32'h1);
    idle(1);
    check("lat_n9_busy", 32'(busy), 32'h0);
    check("static_ch2", 32'(dout_p), 32'h04);
    check("static_ch2_n", 32'(dout_n), 32'hFB);

    // Break-before-make 2 -> 3, cycle by cycle
    wr(3'd2, 16'h0003);
    zeros = 0; busys = 0; badn = 0; multi = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (dout_n !== ~dout_p) badn++;
      if ($countones(dout_p) > 1) multi++;
      if (dout_p == 8'h00) zeros++;
      if (busy) busys++;
      if (c == 4) check("bbm_last_old", 32'(dout_p), 32'h04);
      if (c == 5) check("bbm_first_gap", 32'(dout_p), 32'h00);
      if (c == 9) check("bbm_new", 32'(dout_p), 32'h08);
    end
    check("bbm_gap_len", 32'(zeros), 32'd4);
    check("bbm_busy_len", 32'(busys), 32'd4);
    check("bbm_dout_n", 32'(badn), 32'd0);
    check("bbm_overlap", 32'(multi), 32'd0);

    rd(3'd4, rdat);
    check("status_on_ch3", 32'(rdat), 32'h0013);

    // SEL points at a disabled channel: gap, then stays off
    wr(3'd2, 16'h0005);
    idle(5);
    check("sel5_bbm", 32'(busy), 32'h1);
    idle(10);
    check("sel5_off", 32'(dout_p), 32'h00);
    check("sel5_off_n", 32'(dout_n), 32'hFF);
    check("sel5_busy", 32'(busy), 32'h0);

    // Readback
    wr(3'd3, 16'hA5C3); idle(5);
    rd(3'd3, rdat);
    check("rd_div", 32'(rdat), 32'hA5C3);
    wr(3'd6, 16'hFFFF); idle(5);
    rd(3'd6, rdat);
    check("rd_addr6", 32'(rdat), 32'h0000);
    rd(3'd1, rdat);
    check("rd_mode", 32'(rdat), 32'h0001);

    // Malformed frames leave SEL and outputs alone
    wr(3'd2, 16'h0002); idle(15);
    check("pre_bad_ch2", 32'(dout_p), 32'h04);
    xfer(23, frm(1'b1, 3'd2, 16'h0003) >> 1, rdat); idle(15);
    check("bad23_dout", 32'(dout_p), 32'h04);
    xfer(25, frm(1'b1, 3'd2, 16'h0003) | 32'h0100_0000, rdat); idle(15);
    check("bad25_dout", 32'(dout_p), 32'h04);
    rd(3'd2, rdat);
    check("bad_sel_kept", 32'(rdat), 32'h0002);

    // Scan over EN = 0x85 with DIV = 9
    wr(3'd0, 16'h0085);
    wr(3'd3, 16'h0009);
    wr(3'd1, 16'h0002);
    w = 0;
    while (dout_p !== 8'h01 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("scan_start", 32'(w < 300), 32'h1);
    for (int s = 0; s < 6; s++) begin
      v = dout_p;
      n = 0;
      while (dout_p === v && n < 100) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("scan_val%0d", s), 32'(v), 32'(seg_val[s]));
      check($sformatf("scan_len%0d", s), 32'(n), 32'(seg_len[s]));
    end
    check("scan_wrap", 32'(dout_p), 32'h01);
    wr(3'd0, 16'h0000); idle(15);
    check("scan_en0_off", 32'(dout_p), 32'h00);
    check("scan_en0_busy", 32'(busy), 32'h0);

    // Reset in the middle of a gap
    wr(3'd0, 16'h000F); wr(3'd2, 16'h0001); wr(3'd1, 16'h0001); idle(15);
    check("pre_rst_ch1", 32'(dout_p), 32'h02);
    wr(3'd2, 16'h0003);
    idle(6);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_bbm_dout", 32'(dout_p), 32'h00);
    check("rst_bbm_dout_n", 32'(dout_n), 32'hFF);
    check("rst_bbm_busy", 32'(busy), 32'h0);
    #2 rst = 1'b0;
    idle(5);

    // Reset in the middle of a read frame
    wr(3'd3, 16'hFFFF); idle(5);
    @(negedge clk);
    ss = 1'b0;
    #50;
    shift_bits(12, frm(1'b0, 3'd3, 16'h0) >> 12, rdat);
    idle(6);
    check("pre_rst_miso", 32'(miso), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_frame_miso", 32'(miso), 32'h0);
    check("rst_frame_dout", 32'(dout_p), 32'h00);
    #2 rst = 1'b0;
    idle(3);
    ss = 1'b1;
    idle(10);
    rd(3'd3, rdat);
    check("post_rst_div", 32'(rdat), 32'h0000);
    wr(3'd0, 16'h00FF); idle(5);
    rd(3'd0, rdat);
    check("post_rst_en", 32'(rdat), 32'h00FF);
    check("post_rst_dout", 32'(dout_p), 32'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
